// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - radix-2 restoring integer divide sequencer for the EX stage
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   start_i     divide request from EX, held until ready_o or annul_i
//   annul_i     abort current/pending divide (pipeline flush), beats start_i
//   signed_i    1 = signed divide (only honoured when DIV_SIGNED_EN is defined)
//   op_a_i      dividend, sampled at acceptance
//   op_b_i      divisor, sampled at acceptance
//   result_o    {remainder, quotient}, registered, held until next completion
//   ready_o     one-cycle result-valid pulse, registered
//   stallreq_o  EX stall request, combinational
//
// Build option: DIV_SIGNED_EN enables signed division; without it all divides
// are unsigned and the magnitude/negation logic is absent.
module div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     op_a_i,
  input  logic [DATA_W-1:0]     op_b_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  localparam int              CNT_W     = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  // Holds the dividend magnitude; quotient bits are shifted into the LSBs as
  // dividend bits leave the MSB, so after DATA_W steps it holds the quotient.
  // In BYZERO it carries the raw op_a for the remainder field.
  logic [DATA_W-1:0]   r_dividend;
  logic [DATA_W-1:0]   r_divisor;
  logic [DATA_W-1:0]   r_rem;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;

  logic [DATA_W-1:0]   w_a_mag;
  logic [DATA_W-1:0]   w_b_mag;
  logic [DATA_W:0]     w_trial;
  logic [DATA_W:0]     w_diff;
  logic                w_qbit;
  logic [DATA_W-1:0]   w_rem_next;
  logic [DATA_W-1:0]   w_quot_next;
  logic [DATA_W-1:0]   w_quot_fin;
  logic [DATA_W-1:0]   w_rem_fin;
  logic                w_abort;

  // Trial subtract on DATA_W+1 bits; the top bit of the difference is the borrow.
  assign w_trial     = {r_rem, r_dividend[DATA_W-1]};
  assign w_diff      = w_trial - {1'b0, r_divisor};
  assign w_qbit      = ~w_diff[DATA_W];
  assign w_rem_next  = w_qbit ? w_diff[DATA_W-1:0] : w_trial[DATA_W-1:0];
  assign w_quot_next = {r_dividend[DATA_W-2:0], w_qbit};

  assign w_abort = annul_i | ~start_i;

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_a_neg;
  logic w_b_neg;

  assign w_a_neg    = signed_i & op_a_i[DATA_W-1];
  assign w_b_neg    = signed_i & op_b_i[DATA_W-1];
  assign w_a_mag    = w_a_neg ? -op_a_i : op_a_i;
  assign w_b_mag    = w_b_neg ? -op_b_i : op_b_i;
  // Most-negative / -1 falls out naturally: the magnitude quotient 2^(W-1)
  // is left un-negated and reads back as the most-negative value.
  assign w_quot_fin = r_neg_q ? -w_quot_next : w_quot_next;
  assign w_rem_fin  = r_neg_r ? -w_rem_next  : w_rem_next;
`else
  logic w_unused_signed;

  assign w_unused_signed = signed_i;
  assign w_a_mag         = op_a_i;
  assign w_b_mag         = op_b_i;
  assign w_quot_fin      = w_quot_next;
  assign w_rem_fin       = w_rem_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_result   <= '0;
      r_ready    <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
`endif
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_divisor <= w_b_mag;
`ifdef DIV_SIGNED_EN
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
`endif
            if (op_b_i == '0) begin
              r_dividend <= op_a_i;
              r_state    <= S_BYZERO;
            end else begin
              r_dividend <= w_a_mag;
              r_state    <= S_ON;
            end
          end
        end
        S_BYZERO: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= {r_dividend, {DATA_W{1'b1}}};
            r_ready  <= 1'b1;
            r_state  <= S_END;
          end
        end
        S_ON: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_rem      <= w_rem_next;
            r_dividend <= w_quot_next;
            r_cnt      <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_ITER) begin
              r_result <= {w_rem_fin, w_quot_fin};
              r_ready  <= 1'b1;
              r_state  <= S_END;
            end
          end
        end
        S_END:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  // Gated by rst so the request drops the moment reset is asserted.
  assign stallreq_o = ~rst & ~annul_i &
                      (((r_state == S_IDLE) & start_i) |
                       (r_state == S_BYZERO) | (r_state == S_ON));

endmodule
